// File: rtl/hw_stack_ram.sv
// hw_stack_ram: simple-dual-port inferred block RAM backing the hardware stack.
//
// Ports:
//   clk    - system clock
//   we     - write enable
//   waddr  - write address
//   wdata  - write data
//   re     - read enable
//   raddr  - read address
//   rdata  - registered read data; holds its value while re is low
//
// A read and a write to the same address in one cycle return the old
// contents, which is what a replace-top operation relies on.
module hw_stack_ram #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 128,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [PTR_W-1:0] waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [PTR_W-1:0] raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/hw_stack.sv
// hw_stack: parametrised LIFO stack (return addresses, saved registers).
//
// Ports:
//   clk       - system clock
//   reset     - synchronous, active-high reset
//   d         - data to push
//   push/pop  - stack requests; both together replace the top entry
//   clear     - pipeline flush: blocks push/pop, zeroes q
//   hold      - pipeline stall: blocks push/pop, holds q
//   err_clr   - clears the sticky overflow/underflow flags
//   q         - result of the last accepted pop (1-cycle latency)
//   count     - occupancy, 0..DEPTH
//   empty     - count == 0
//   full      - count == DEPTH
//   overflow  - sticky: push attempted while full
//   underflow - sticky: pop attempted while empty
module hw_stack #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 128,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    input  logic             push,
    input  logic             pop,
    input  logic             clear,
    input  logic             hold,
    input  logic             err_clr,
    output logic [WIDTH-1:0] q,
    output logic [PTR_W:0]   count,
    output logic             empty,
    output logic             full,
    output logic             overflow,
    output logic             underflow
);

    localparam logic [PTR_W:0]   FULL_CNT = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W + 1)'(1);
    localparam logic [PTR_W-1:0] ADR_ONE  = PTR_W'(1);

    logic             active;
    logic             push_ok;
    logic             pop_ok;
    logic             replace;
    logic             bypass;
    logic             ovf_set;
    logic             unf_set;
    logic [PTR_W-1:0] top_addr;
    logic [PTR_W:0]   count_next;

    logic             ram_we;
    logic [PTR_W-1:0] ram_waddr;
    logic             ram_re;
    logic [WIDTH-1:0] ram_rdata;

    // q is either the RAM read register (after a pop/replace) or a local
    // register (after reset, clear or bypass); from_ram selects between them.
    // The RAM read register only changes when re is high, so it holds q
    // across idle, push-only and blocked cycles.
    logic [WIDTH-1:0] q_local;
    logic             from_ram;

    // With count == DEPTH the low PTR_W bits wrap to 0, so subtracting one
    // in PTR_W bits still lands on DEPTH-1.
    assign top_addr = count[PTR_W-1:0] - ADR_ONE;

    always_comb begin
        active  = !reset && !clear && !hold;
        push_ok = active && push && !pop && !full;
        pop_ok  = active && pop && !push && !empty;
        replace = active && push && pop && !empty;
        bypass  = active && push && pop && empty;
        ovf_set = active && push && !pop && full;
        unf_set = active && pop && !push && empty;

        count_next = count;
        if (push_ok) begin
            count_next = count + CNT_ONE;
        end else if (pop_ok) begin
            count_next = count - CNT_ONE;
        end

        ram_we    = push_ok || replace;
        ram_waddr = push_ok ? count[PTR_W-1:0] : top_addr;
        ram_re    = pop_ok || replace;
    end

    hw_stack_ram #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH)
    ) u_ram (
        .clk  (clk),
        .we   (ram_we),
        .waddr(ram_waddr),
        .wdata(d),
        .re   (ram_re),
        .raddr(top_addr),
        .rdata(ram_rdata)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            count     <= '0;
            empty     <= 1'b1;
            full      <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
            q_local   <= '0;
            from_ram  <= 1'b0;
        end else begin
            count <= count_next;
            empty <= (count_next == '0);
            full  <= (count_next == FULL_CNT);

            // A new error in the same cycle as err_clr keeps the flag set.
            if (ovf_set) begin
                overflow <= 1'b1;
            end else if (err_clr) begin
                overflow <= 1'b0;
            end
            if (unf_set) begin
                underflow <= 1'b1;
            end else if (err_clr) begin
                underflow <= 1'b0;
            end

            if (clear) begin
                q_local  <= '0;
                from_ram <= 1'b0;
            end else if (bypass) begin
                q_local  <= d;
                from_ram <= 1'b0;
            end else if (pop_ok || replace) begin
                from_ram <= 1'b1;
            end
        end
    end

    assign q = from_ram ? ram_rdata : q_local;

endmodule

// File: tb/tb_hw_stack.sv
module tb_hw_stack;

    localparam int WIDTH = 32;
    localparam int DEPTH = 4;
    localparam int PTR_W = $clog2(DEPTH);

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [WIDTH-1:0] d = '0;
    logic             push = 1'b0;
    logic             pop = 1'b0;
    logic             clear = 1'b0;
    logic             hold = 1'b0;
    logic             err_clr = 1'b0;
    logic [WIDTH-1:0] q;
    logic [PTR_W:0]   count;
    logic             empty;
    logic             full;
    logic             overflow;
    logic             underflow;

    always #5 clk = ~clk;

    hw_stack #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .d        (d),
        .push     (push),
        .pop      (pop),
        .clear    (clear),
        .hold     (hold),
        .err_clr  (err_clr),
        .q        (q),
        .count    (count),
        .empty    (empty),
        .full     (full),
        .overflow (overflow),
        .underflow(underflow)
    );

    typedef struct {
        logic             rst;
        logic             psh;
        logic             pp;
        logic             clr;
        logic             hld;
        logic             eclr;
        logic [WIDTH-1:0] din;
        logic [WIDTH-1:0] eq;
        int               ecnt;
        logic             eempty;
        logic             efull;
        logic             eovf;
        logic             eunf;
    } vec_t;

    typedef struct {
        string            name;
        logic [WIDTH-1:0] eq;
        int               ecnt;
        logic             eempty;
        logic             efull;
        logic             eovf;
        logic             eunf;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;

    function automatic vec_t mk(logic rst, logic psh, logic pp, logic clr, logic hld,
                                logic eclr, logic [WIDTH-1:0] din, logic [WIDTH-1:0] eq,
                                int ecnt, logic ee, logic ef, logic eo, logic eu);
        vec_t v;
        v.rst = rst; v.psh = psh; v.pp = pp; v.clr = clr; v.hld = hld; v.eclr = eclr;
        v.din = din; v.eq = eq; v.ecnt = ecnt; v.eempty = ee; v.efull = ef;
        v.eovf = eo; v.eunf = eu;
        return v;
    endfunction

    // Drive one cycle of stimulus, queue its expectation, and check after the edge.
    task automatic apply(input string name, input vec_t v);
        exp_t e;
        exp_t got;
        @(negedge clk);
        reset = v.rst; push = v.psh; pop = v.pp; clear = v.clr; hold = v.hld;
        err_clr = v.eclr; d = v.din;
        e.name = name; e.eq = v.eq; e.ecnt = v.ecnt; e.eempty = v.eempty;
        e.efull = v.efull; e.eovf = v.eovf; e.eunf = v.eunf;
        sb.push_back(e);
        @(posedge clk);
        #1;
        vectors++;
        if (sb.size() == 0) begin
            miscompares++;
            $display("FAIL %s: scoreboard empty", name);
        end else begin
            got = sb.pop_front();
            if (q !== got.eq || int'(count) != got.ecnt || empty !== got.eempty ||
                full !== got.efull || overflow !== got.eovf || underflow !== got.eunf) begin
                miscompares++;
                $display("FAIL %s: got q=%h count=%0d empty=%b full=%b ovf=%b unf=%b, expected q=%h count=%0d empty=%b full=%b ovf=%b unf=%b",
                         got.name, q, count, empty, full, overflow, underflow,
                         got.eq, got.ecnt, got.eempty, got.efull, got.eovf, got.eunf);
            end
        end
    endtask

    initial begin
        //          rst psh pop clr hld ecl d      | q   cnt e f o u
        // Reset state and basic LIFO order
        tbl.push_back(mk(1,0,0,0,0,0, 32'h00, 32'h00, 0,1,0,0,0));
        tbl.push_back(mk(0,1,0,0,0,0, 32'h11, 32'h00, 1,0,0,0,0));
        tbl.push_back(mk(0,1,0,0,0,0, 32'h22, 32'h00, 2,0,0,0,0));
        tbl.push_back(mk(0,1,0,0,0,0, 32'h33, 32'h00, 3,0,0,0,0));
        tbl.push_back(mk(0,0,1,0,0,0, 32'h00, 32'h33, 2,0,0,0,0));
        tbl.push_back(mk(0,0,1,0,0,0, 32'h00, 32'h22, 1,0,0,0,0));
        tbl.push_back(mk(0,0,1,0,0,0, 32'h00, 32'h11, 0,1,0,0,0));
        // Fill to full, overflow, err_clr
        tbl.push_back(mk(0,1,0,0,0,0, 32'h01, 32'h11, 1,0,0,0,0));
        tbl.push_back(mk(0,1,0,0,0,0, 32'h02, 32'h11, 2,0,0,0,0));
        tbl.push_back(mk(0,1,0,0,0,0, 32'h03, 32'h11, 3,0,0,0,0));
        tbl.push_back(mk(0,1,0,0,0,0, 32'h04, 32'h11, 4,0,1,0,0));
        tbl.push_back(mk(0,1,0,0,0,0, 32'h05, 32'h11, 4,0,1,1,0));
        tbl.push_back(mk(0,0,1,0,0,0, 32'h00, 32'h04, 3,0,0,1,0));
        tbl.push_back(mk(0,0,0,0,0,1, 32'h00, 32'h04, 3,0,0,0,0));
        tbl.push_back(mk(0,0,1,0,0,0, 32'h00, 32'h03, 2,0,0,0,0));
        tbl.push_back(mk(0,0,1,0,0,0, 32'h00, 32'h02, 1,0,0,0,0));
        tbl.push_back(mk(0,0,1,0,0,0, 32'h00, 32'h01, 0,1,0,0,0));
        // Underflow from empty, then bypass push+pop
        tbl.push_back(mk(0,0,1,0,0,0, 32'h00, 32'h01, 0,1,0,0,1));
        tbl.push_back(mk(0,1,1,0,0,0, 32'h07, 32'h07, 0,1,0,0,1));
        tbl.push_back(mk(0,0,0,0,0,1, 32'h00, 32'h07, 0,1,0,0,0));
        // Replace top
        tbl.push_back(mk(0,1,0,0,0,0, 32'h0A, 32'h07, 1,0,0,0,0));
        tbl.push_back(mk(0,1,0,0,0,0, 32'h0B, 32'h07, 2,0,0,0,0));
        tbl.push_back(mk(0,1,1,0,0,0, 32'h0C, 32'h0B, 2,0,0,0,0));
        tbl.push_back(mk(0,0,1,0,0,0, 32'h00, 32'h0C, 1,0,0,0,0));
        tbl.push_back(mk(0,0,1,0,0,0, 32'h00, 32'h0A, 0,1,0,0,0));
        // Hold and clear
        tbl.push_back(mk(0,1,0,0,0,0, 32'h05, 32'h0A, 1,0,0,0,0));
        tbl.push_back(mk(0,1,0,0,0,0, 32'h06, 32'h0A, 2,0,0,0,0));
        tbl.push_back(mk(0,0,1,0,1,0, 32'h00, 32'h0A, 2,0,0,0,0));
        tbl.push_back(mk(0,0,1,1,0,0, 32'h00, 32'h00, 2,0,0,0,0));
        tbl.push_back(mk(0,0,1,0,0,0, 32'h00, 32'h06, 1,0,0,0,0));
        // Reset wins over pop mid-operation
        tbl.push_back(mk(0,1,0,0,0,0, 32'h01, 32'h06, 2,0,0,0,0));
        tbl.push_back(mk(0,1,0,0,0,0, 32'h02, 32'h06, 3,0,0,0,0));
        tbl.push_back(mk(1,0,1,0,0,0, 32'h00, 32'h00, 0,1,0,0,0));
        tbl.push_back(mk(0,0,1,0,0,0, 32'h00, 32'h00, 0,1,0,0,1));

        for (int i = 0; i < tbl.size(); i++) begin
            apply($sformatf("vec%0d", i), tbl[i]);
        end

        // Replace-top while full, error set racing err_clr, clear blocking push
        apply("h_errclr",   mk(0,0,0,0,0,1, 32'h00, 32'h00, 0,1,0,0,0));
        apply("h_push41",   mk(0,1,0,0,0,0, 32'h41, 32'h00, 1,0,0,0,0));
        apply("h_push42",   mk(0,1,0,0,0,0, 32'h42, 32'h00, 2,0,0,0,0));
        apply("h_push43",   mk(0,1,0,0,0,0, 32'h43, 32'h00, 3,0,0,0,0));
        apply("h_push44",   mk(0,1,0,0,0,0, 32'h44, 32'h00, 4,0,1,0,0));
        apply("h_repfull",  mk(0,1,1,0,0,0, 32'h55, 32'h44, 4,0,1,0,0));
        apply("h_ovf",      mk(0,1,0,0,0,0, 32'h66, 32'h44, 4,0,1,1,0));
        apply("h_setwins",  mk(0,1,0,0,0,1, 32'h77, 32'h44, 4,0,1,1,0));
        apply("h_pop55",    mk(0,0,1,0,0,0, 32'h00, 32'h55, 3,0,0,1,0));
        apply("h_clrpush",  mk(0,1,0,1,0,0, 32'h99, 32'h00, 3,0,0,1,0));
        apply("h_holdpush", mk(0,1,0,0,1,0, 32'h98, 32'h00, 3,0,0,1,0));
        apply("h_pop43",    mk(0,0,1,0,0,0, 32'h00, 32'h43, 2,0,0,1,0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
